pong_game_ctrl: RTL

- Game sequencer for the pong datapath: attract, serve, play, point-scored, game-over.
- Tracks both players' scores and decides when the ball datapath is held at centre, frozen, or running.
- Sets the serve direction.
- Runs in the pixel clock domain and advances its timers on a one-cycle frame tick derived from vsync; outputs drive the ball/paddle logic and the score overlay.

---
 rtl/pong_game_ctrl_if.sv | 28 ++
 rtl/pong_game_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl_if.sv
// Control/status bundle between the pong sequencer and the ball/paddle/overlay logic.
// The game side drives frame timing, the start button and misses; the sequencer returns ball control and scores.
interface pong_game_ctrl_if #(
  parameter int SCORE_W = 4
);
  logic               frame_tick;
  logic               start;
  logic               miss_left;
  logic               miss_right;
  logic               ball_reset;
  logic               ball_run;
  logic               serve_dir;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic [1:0]         winner;
  logic               flash;
  logic [2:0]         state;

  modport master (
    output frame_tick, start, miss_left, miss_right,
    input  ball_reset, ball_run, serve_dir, score1, score2, winner, flash, state
  );

  modport slave (
    input  frame_tick, start, miss_left, miss_right,
    output ball_reset, ball_run, serve_dir, score1, score2, winner, flash, state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: attract -> serve -> play -> point/over, with score keeping
// and frame-tick timers. Every output is a register or a decode of registered state.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 11,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int FRAME_CNT_W  = 7
) (
  input  logic            clk,
  input  logic            reset,
  pong_game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [SCORE_W-1:0]     WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [FRAME_CNT_W-1:0] SERVE_LAST = FRAME_CNT_W'(SERVE_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] POINT_LAST = FRAME_CNT_W'(POINT_FRAMES - 1);

  state_t                 st_q, st_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic [SCORE_W-1:0]     s1_q, s1_d, s2_q, s2_d;
  logic [SCORE_W-1:0]     s1_inc, s2_inc;
  logic [1:0]             win_q, win_d;
  logic                   dir_q, dir_d;
  logic                   start_q;
  logic                   start_edge;

  // start_q resets high so a button held through reset needs a release first
  assign start_edge = bus.start & ~start_q;
  assign s1_inc     = s1_q + 1'b1;
  assign s2_inc     = s2_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= S_IDLE;
      cnt_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      win_q   <= 2'd0;
      dir_q   <= 1'b1;
      start_q <= 1'b1;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      win_q   <= win_d;
      dir_q   <= dir_d;
      start_q <= bus.start;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    s1_d  = s1_q;
    s2_d  = s2_q;
    win_d = win_q;
    dir_d = dir_q;
    case (st_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          st_d  = S_SERVE;
          cnt_d = '0;
          s1_d  = '0;
          s2_d  = '0;
          win_d = 2'd0;
          dir_d = 1'b1;
        end else if (st_q == S_OVER && bus.frame_tick) begin
          cnt_d = cnt_q + 1'b1;  // free-running blink timer, wraps naturally
        end
      end
      S_SERVE: begin
        if (bus.frame_tick) begin
          if (cnt_q == SERVE_LAST) begin
            cnt_d = '0;
            st_d  = S_PLAY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_PLAY: begin
        // a let (both sides miss together) replays the serve without scoring
        case ({bus.miss_left, bus.miss_right})
          2'b11: begin
            st_d  = S_SERVE;
            cnt_d = '0;
          end
          2'b10: begin
            s2_d  = s2_inc;
            dir_d = 1'b0;
            cnt_d = '0;
            if (s2_inc == WIN) begin
              st_d  = S_OVER;
              win_d = 2'd2;
            end else begin
              st_d  = S_POINT;
            end
          end
          2'b01: begin
            s1_d  = s1_inc;
            dir_d = 1'b1;
            cnt_d = '0;
            if (s1_inc == WIN) begin
              st_d  = S_OVER;
              win_d = 2'd1;
            end else begin
              st_d  = S_POINT;
            end
          end
          default: ;
        endcase
      end
      S_POINT: begin
        if (bus.frame_tick) begin
          if (cnt_q == POINT_LAST) begin
            cnt_d = '0;
            st_d  = S_SERVE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  assign bus.state      = st_q;
  assign bus.score1     = s1_q;
  assign bus.score2     = s2_q;
  assign bus.winner     = win_q;
  assign bus.serve_dir  = dir_q;
  assign bus.ball_run   = (st_q == S_PLAY);
  assign bus.ball_reset = !((st_q == S_PLAY) || (st_q == S_POINT));

  generate
    if (FRAME_CNT_W > 3) begin : g_flash
      assign bus.flash = ((st_q == S_POINT) || (st_q == S_OVER)) && cnt_q[3];
    end else begin : g_noflash
      assign bus.flash = 1'b0;
    end
  endgenerate

endmodule
